// File: rtl/io_pkg.sv
// Shared constants, vector types and the ms-to-cycles helper for the board I/O front end.
package io_pkg;

    localparam int N_BTN_DEFAULT = 5;
    localparam int N_SW_DEFAULT  = 16;

    typedef logic [N_BTN_DEFAULT-1:0] btn_vec_t;
    typedef logic [N_SW_DEFAULT-1:0]  sw_vec_t;

    // Rounds to the nearest whole cycle and never returns less than one.
    function automatic int cycles_from_ms(real mhz, real ms);
        int c;
        c = int'(mhz * 1000.0 * ms);
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/io_debounce_bit.sv
// One input line: multi-flop synchroniser, stability counter and debounced level.
// chg_o is a registered one-cycle pulse on the same edge level_o changes.
module io_debounce_bit #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o,
    output logic chg_o
);

    localparam int            CW       = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_TERM = CW'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [CW-1:0]          cnt_q;

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_o <= 1'b0;
            chg_o   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
            chg_o  <= 1'b0;
            // Any sample matching the current level restarts the stability window.
            if (sync == level_o) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_TERM) begin
                level_o <= sync;
                chg_o   <= 1'b1;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_input_conditioner.sv
// Synchronises and debounces board buttons/switches, emitting clean levels and edge pulses.
// Long-press detection is built only when IO_COND_LONGPRESS_EN is defined.
module io_input_conditioner
    import io_pkg::*;
#(
    parameter real CLK_FREQ     = 100.0,
    parameter real DEBOUNCE_MS  = 10.0,
`ifdef IO_COND_LONGPRESS_EN
    parameter real LONGPRESS_MS = 1000.0,
`endif
    parameter int  N_BTN        = N_BTN_DEFAULT,
    parameter int  N_SW         = N_SW_DEFAULT,
    parameter int  SYNC_STAGES  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw_i,
    input  logic [N_SW-1:0]  sw_raw_i,
    output logic [N_BTN-1:0] btn_o,
    output logic [N_SW-1:0]  sw_o,
    output logic [N_BTN-1:0] btn_rise_o,
    output logic [N_BTN-1:0] btn_fall_o,
    output logic [N_BTN-1:0] btn_long_o,
    output logic             change_o
);

    localparam int DB_CYCLES = cycles_from_ms(CLK_FREQ, DEBOUNCE_MS);

    logic [N_BTN-1:0] btn_chg;
    logic [N_SW-1:0]  sw_chg;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        io_debounce_bit #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_db (
            .clk     (clk),
            .rst     (rst),
            .raw_i   (btn_raw_i[i]),
            .level_o (btn_o[i]),
            .chg_o   (btn_chg[i])
        );
    end

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        io_debounce_bit #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_db (
            .clk     (clk),
            .rst     (rst),
            .raw_i   (sw_raw_i[i]),
            .level_o (sw_o[i]),
            .chg_o   (sw_chg[i])
        );
    end

    // chg and level are both registered, so the direction is known on the changing edge.
    assign btn_rise_o = btn_chg & btn_o;
    assign btn_fall_o = btn_chg & ~btn_o;
    assign change_o   = |{btn_chg, sw_chg};

`ifdef IO_COND_LONGPRESS_EN
    localparam int            LP_CYCLES = cycles_from_ms(CLK_FREQ, LONGPRESS_MS);
    localparam int            HW        = $clog2(LP_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_TERM = HW'(LP_CYCLES - 1);

    for (genvar i = 0; i < N_BTN; i++) begin : g_long
        logic [HW-1:0] hold_q;
        logic          long_q;

        // Counter parks at its terminal value so each press yields a single pulse.
        always_ff @(posedge clk) begin
            if (rst || !btn_o[i]) begin
                hold_q <= '0;
                long_q <= 1'b0;
            end else if (hold_q != HOLD_TERM) begin
                hold_q <= hold_q + 1'b1;
                long_q <= (hold_q == HOLD_TERM - 1'b1);
            end else begin
                long_q <= 1'b0;
            end
        end

        assign btn_long_o[i] = long_q;
    end
`else
    assign btn_long_o = '0;
`endif

endmodule

// File: tb/tb_io_input_conditioner.sv
// Randomised and directed bench for io_input_conditioner against a window-based reference model.
module tb_io_input_conditioner;

    localparam int N_BTN = 5;
    localparam int N_SW  = 16;
    localparam int NL    = N_BTN + N_SW;
    localparam int SYNC  = 2;
    localparam int DB    = 10;
    localparam int LP    = 50;
`ifdef IO_COND_LONGPRESS_EN
    localparam bit LP_ON = 1'b1;
`else
    localparam bit LP_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst;
    logic [N_BTN-1:0] btn_raw_i;
    logic [N_SW-1:0]  sw_raw_i;
    logic [N_BTN-1:0] btn_o, btn_rise_o, btn_fall_o, btn_long_o;
    logic [N_SW-1:0]  sw_o;
    logic             change_o;

    always #5 clk = ~clk;

    io_input_conditioner #(
        .CLK_FREQ     (1.0),
        .DEBOUNCE_MS  (0.01),
`ifdef IO_COND_LONGPRESS_EN
        .LONGPRESS_MS (0.05),
`endif
        .N_BTN        (N_BTN),
        .N_SW         (N_SW),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw_i  (btn_raw_i),
        .sw_raw_i   (sw_raw_i),
        .btn_o      (btn_o),
        .sw_o       (sw_o),
        .btn_rise_o (btn_rise_o),
        .btn_fall_o (btn_fall_o),
        .btn_long_o (btn_long_o),
        .change_o   (change_o)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A line's level flips on an edge when the last DB synchronised samples all disagree
    // with it; the synchronised sample seen on edge k is the raw value from edge k-SYNC.
    logic [NL-1:0]    raw_hist[$];
    logic [NL-1:0]    seen_hist[$];
    logic [NL-1:0]    m_level;
    logic [NL-1:0]    m_chg;
    logic [N_BTN-1:0] m_long;
    int               m_edge;
    int               rise_at[N_BTN];

    task automatic model_step(input logic rst_v, input logic [NL-1:0] raw_v);
        logic [NL-1:0] seen;
        bit            all_diff;
        if (rst_v) begin
            raw_hist.delete();
            seen_hist.delete();
            m_level = '0;
            m_chg   = '0;
            m_long  = '0;
            m_edge  = 0;
            return;
        end
        seen = (raw_hist.size() >= SYNC) ? raw_hist[raw_hist.size() - SYNC] : '0;
        raw_hist.push_back(raw_v);
        seen_hist.push_back(seen);
        if (raw_hist.size() > SYNC + 4) void'(raw_hist.pop_front());
        if (seen_hist.size() > DB + 4) void'(seen_hist.pop_front());
        m_chg = '0;
        if (seen_hist.size() >= DB) begin
            for (int j = 0; j < NL; j++) begin
                all_diff = 1'b1;
                for (int d = 0; d < DB; d++)
                    if (seen_hist[seen_hist.size() - 1 - d][j] == m_level[j]) all_diff = 1'b0;
                if (all_diff) begin
                    m_level[j] = ~m_level[j];
                    m_chg[j]   = 1'b1;
                    if (j < N_BTN && m_level[j]) rise_at[j] = m_edge;
                end
            end
        end
        for (int j = 0; j < N_BTN; j++)
            m_long[j] = LP_ON && m_level[j] && (m_edge - rise_at[j] == LP - 1);
        m_edge++;
    endtask

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        model_step(rst, {sw_raw_i, btn_raw_i});
        @(negedge clk);
        check("btn_o",  32'(btn_o),      32'(m_level[N_BTN-1:0]));
        check("sw_o",   32'(sw_o),       32'(m_level[NL-1:N_BTN]));
        check("rise",   32'(btn_rise_o), 32'(m_chg[N_BTN-1:0] & m_level[N_BTN-1:0]));
        check("fall",   32'(btn_fall_o), 32'(m_chg[N_BTN-1:0] & ~m_level[N_BTN-1:0]));
        check("long",   32'(btn_long_o), 32'(m_long));
        check("change", 32'(change_o),   32'(|m_chg));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Edges until btn_o[idx] reaches want, bounded; returns -1 on timeout.
    task automatic measure_btn(input int idx, input logic want, output int edges);
        edges = -1;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (btn_o[idx] === want) begin
                edges = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int long_cnt;
        rst       = 1'b1;
        btn_raw_i = '0;
        sw_raw_i  = '0;
        for (int j = 0; j < N_BTN; j++) rise_at[j] = 0;
        run(3);
        rst = 1'b0;
        run(3);

        // Single button press: exact latency.
        btn_raw_i = 5'b00001;
        measure_btn(0, 1'b1, lat);
        check("rise_latency", 32'(lat), 32'd12);
        run(20);

        // Bouncing switch settles once.
        for (int i = 0; i < 40; i++) begin
            if (i % 4 == 0) sw_raw_i[3] = ~sw_raw_i[3];
            step();
        end
        sw_raw_i[3] = 1'b1;
        run(30);
        check("sw3_settled", 32'(sw_o[3]), 32'd1);

        // Release: exact latency.
        btn_raw_i[0] = 1'b0;
        measure_btn(0, 1'b0, lat);
        check("fall_latency", 32'(lat), 32'd12);
        run(5);

        // Simultaneous button and switch step.
        btn_raw_i[2] = 1'b1;
        sw_raw_i[15] = 1'b1;
        run(20);

        // Reset mid-debounce discards the partial count.
        btn_raw_i[1] = 1'b1;
        run(5);
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        measure_btn(1, 1'b1, lat);
        check("post_rst_latency", 32'(lat), 32'd12);
        run(10);

        // Long hold on button 4.
        long_cnt = 0;
        btn_raw_i[4] = 1'b1;
        for (int i = 0; i < 200; i++) begin
            step();
            if (btn_long_o[4] === 1'b1) long_cnt++;
        end
        check("long_pulses", 32'(long_cnt), LP_ON ? 32'd1 : 32'd0);
        btn_raw_i[4] = 1'b0;
        run(20);

        // Random toggling with occasional resets.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 7) == 0) btn_raw_i[$urandom_range(0, N_BTN - 1)] ^= 1'b1;
            if ($urandom_range(0, 5) == 0) sw_raw_i[$urandom_range(0, N_SW - 1)] ^= 1'b1;
            rst = ($urandom_range(0, 399) == 0);
            step();
        end
        rst = 1'b0;
        run(80);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
